// File: rtl/module_escritura_cod_gray_pkg.sv
// Shared definitions for the Gray-code writer and reader blocks.
package module_escritura_cod_gray_pkg;

    localparam int DEFAULT_WIDTH   = 4;
    localparam int DEFAULT_REFRESH = 2700000;
    // Widest code the helpers handle; callers cast the result to their own WIDTH.
    localparam int GRAY_MAX_W      = 32;

    // Binary to reflected Gray: each bit is the XOR of itself and the next higher bit.
    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] gray);
        logic [GRAY_MAX_W-1:0] bin;
        bin[GRAY_MAX_W-1] = gray[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/module_tick_refresco.sv
// Free-running refresh prescaler: one-cycle registered tick every PERIOD cycles.
module module_tick_refresco #(
    parameter int PERIOD = 2700000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic restart_i,
    output logic tick_o
);

    localparam int CW = (PERIOD > 2) ? $clog2(PERIOD) : 1;

    logic [CW-1:0] cnt_q;
    logic          tick_q;

    // Down-count to zero, emit the tick and reload. A restart treats its own
    // cycle as the PERIOD-1 slot, so the first tick after it lands exactly
    // PERIOD cycles later; any tick already due is dropped.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cnt_q  <= CW'(PERIOD - 1);
            tick_q <= 1'b0;
        end else if (restart_i) begin
            cnt_q  <= CW'(PERIOD - 2);
            tick_q <= 1'b0;
        end else if (cnt_q == '0) begin
            cnt_q  <= CW'(PERIOD - 1);
            tick_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_q - 1'b1;
            tick_q <= 1'b0;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/module_escritura_cod_gray.sv
// Transmit side of the Gray switch/LED link: up/down count with registered
// binary and Gray outputs plus a one-cycle change strobe.
module module_escritura_cod_gray
    import module_escritura_cod_gray_pkg::*;
#(
    parameter int WIDTH          = DEFAULT_WIDTH,
    parameter int OUTPUT_REFRESH = DEFAULT_REFRESH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             dir_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] bin_load_i,
    output logic [WIDTH-1:0] codigo_gray_o,
    output logic [WIDTH-1:0] codigo_bin_o,
    output logic             cambio_o
);

    logic             tick;
    logic             paso;
    logic             actualiza;
    logic [WIDTH-1:0] cuenta_q;
    logic [WIDTH-1:0] cuenta_d;
    logic [WIDTH-1:0] gray_q;
    logic             cambio_q;

    // A load also restarts the prescaler so the next step is a full period away.
    module_tick_refresco #(
        .PERIOD (OUTPUT_REFRESH)
    ) u_tick (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .restart_i (load_i),
        .tick_o    (tick)
    );

    // Next count: load beats step, step only on an enabled tick, else hold.
    // Step arithmetic wraps modulo 2^WIDTH by construction.
    always_comb begin
        paso      = tick & en_i;
        actualiza = load_i | paso;
        cuenta_d  = cuenta_q;
        if (load_i) begin
            cuenta_d = bin_load_i;
        end else if (paso) begin
            cuenta_d = dir_i ? (cuenta_q - WIDTH'(1)) : (cuenta_q + WIDTH'(1));
        end
    end

    // Both codes come from the same next value so they can never disagree.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cuenta_q <= '0;
            gray_q   <= '0;
            cambio_q <= 1'b0;
        end else begin
            cuenta_q <= cuenta_d;
            gray_q   <= WIDTH'(bin2gray(GRAY_MAX_W'(cuenta_d)));
            cambio_q <= actualiza;
        end
    end

    assign codigo_bin_o  = cuenta_q;
    assign codigo_gray_o = gray_q;
    assign cambio_o      = cambio_q;

endmodule

// File: tb/tb_module_escritura_cod_gray.sv
// Scoreboard bench: a timeline model predicts each output update, the monitor
// matches them against cambio_o strobes and checks holds between updates.
module tb_module_escritura_cod_gray;

    localparam int W = 4;
    localparam int P = 4;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b0;
    logic         en_i = 1'b0;
    logic         dir_i = 1'b0;
    logic         load_i = 1'b0;
    logic [W-1:0] bin_load_i = '0;
    logic [W-1:0] codigo_gray_o;
    logic [W-1:0] codigo_bin_o;
    logic         cambio_o;

    module_escritura_cod_gray #(.WIDTH(W), .OUTPUT_REFRESH(P)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .en_i          (en_i),
        .dir_i         (dir_i),
        .load_i        (load_i),
        .bin_load_i    (bin_load_i),
        .codigo_gray_o (codigo_gray_o),
        .codigo_bin_o  (codigo_bin_o),
        .cambio_o      (cambio_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int bin;
        bit is_step;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   passed = 0;

    // Reference model: edge number, the edge at which the next step is allowed,
    // and the current count as a plain integer.
    int edge_n = 0;
    int next_step_edge = 0;
    int m_cnt = 0;

    function automatic int gray_of(int b);
        return (b ^ (b >> 1)) & ((1 << W) - 1);
    endfunction

    task automatic chk(string name, int act, int exp_v);
        checks++;
        if (act == exp_v) passed++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
    endtask

    // Model: a reset arms the first step PERIOD edges after release; a load
    // arms it PERIOD edges after the load; steps then repeat every PERIOD edges.
    always @(posedge clk_i) begin
        exp_t e;
        edge_n++;
        if (!rst_i) begin
            m_cnt          = 0;
            next_step_edge = edge_n + P + 1;
        end else if (load_i) begin
            m_cnt          = int'(bin_load_i);
            next_step_edge = edge_n + P;
            e.bin = m_cnt; e.is_step = 1'b0;
            sbq.push_back(e);
        end else if (edge_n == next_step_edge) begin
            next_step_edge = edge_n + P;
            if (en_i) begin
                m_cnt = dir_i ? (m_cnt + (1 << W) - 1) % (1 << W) : (m_cnt + 1) % (1 << W);
                e.bin = m_cnt; e.is_step = 1'b1;
                sbq.push_back(e);
            end
        end
    end

    // Monitor: every strobe must match a queued update; between strobes the
    // outputs must hold the model count.
    logic [W-1:0] last_gray = '0;
    always @(negedge clk_i) begin
        exp_t e;
        if (cambio_o === 1'b1) begin
            if (sbq.size() == 0) begin
                chk("spurious_cambio", 1, 0);
            end else begin
                e = sbq.pop_front();
                chk("upd_bin",  int'(codigo_bin_o),  e.bin);
                chk("upd_gray", int'(codigo_gray_o), gray_of(e.bin));
                if (e.is_step) chk("gray_one_bit", $countones(codigo_gray_o ^ last_gray), 1);
            end
        end else begin
            chk("cambio_known", int'(cambio_o === 1'b0), 1);
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                chk("missed_cambio", 0, 1);
            end
            chk("hold_bin",  (codigo_bin_o  === W'(m_cnt))         ? m_cnt : -1, m_cnt);
            chk("hold_gray", (codigo_gray_o === W'(gray_of(m_cnt))) ? 1 : 0, 1);
        end
        last_gray = codigo_gray_o;
    end

    task automatic cycles(int n);
        repeat (n) @(negedge clk_i);
    endtask

    initial begin
        // Reset, then idle with en low: outputs stay at zero, no strobes.
        cycles(3);
        rst_i = 1'b1;
        cycles(20);

        // Count up through a full wrap.
        en_i = 1'b1; dir_i = 1'b0;
        cycles(66);

        // Load 13, then count down past 0 to 15.
        load_i = 1'b1; bin_load_i = 4'd13; dir_i = 1'b1;
        cycles(1);
        load_i = 1'b0;
        cycles(60);

        // Load that collides with a tick: tick is discarded.
        dir_i = 1'b0;
        for (int i = 0; i < 2 * P && (edge_n + 1) != next_step_edge; i++) cycles(1);
        chk("tick_align", edge_n + 1, next_step_edge);
        load_i = 1'b1; bin_load_i = 4'd5;
        cycles(1);
        load_i = 1'b0;
        cycles(10);

        // Reset mid-run dominates a simultaneous load.
        load_i = 1'b1; bin_load_i = 4'd9;
        cycles(1);
        rst_i = 1'b0; bin_load_i = 4'd3;
        cycles(1);
        rst_i = 1'b1; load_i = 1'b0;
        cycles(12);

        // Random mix of enable, direction, loads and occasional resets.
        for (int i = 0; i < 1500; i++) begin
            en_i       = ($urandom_range(0, 3) != 0);
            dir_i      = $urandom_range(0, 1) != 0;
            load_i     = ($urandom_range(0, 15) == 0);
            bin_load_i = W'($urandom_range(0, (1 << W) - 1));
            rst_i      = ($urandom_range(0, 199) != 0);
            cycles(1);
        end

        rst_i = 1'b1; load_i = 1'b0; en_i = 1'b0;
        cycles(4);
        chk("queue_drained", sbq.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
